// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: per-stage hold/clear strobes and PC redirect.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk_100M,
  input  logic        arst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_ram_r_ena_i,
  input  logic [4:0]  ex_reg_w_addr_i,
  input  logic        id_rs1_ena_i,
  input  logic        id_rs2_ena_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        ram_req_i,
  input  logic        ram_ack_i,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        ex_mem_hold_o,
  output logic        if_id_clear_o,
  output logic        id_ex_clear_o,
  output logic        ex_mem_clear_o,
  output logic        mem_wb_clear_o,
  output logic        pc_jump_ena_o,
  output logic [31:0] pc_jump_addr_o,
  output logic [1:0]  state_o,
  output logic        timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic        perf_clr_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [2:0]  flush_left, flush_left_nxt;
  logic        timeout_nxt;
  logic        mem_stall, load_use;
  logic        run_eval, stall_term;

  assign mem_stall = ram_req_i & ~ram_ack_i;
  assign load_use  = ex_ram_r_ena_i & (ex_reg_w_addr_i != 5'd0) &
                     ((id_rs1_ena_i & (id_rs1_addr_i == ex_reg_w_addr_i)) |
                      (id_rs2_ena_i & (id_rs2_addr_i == ex_reg_w_addr_i)));

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    ex_mem_hold_o  = 1'b0;
    if_id_clear_o  = 1'b0;
    id_ex_clear_o  = 1'b0;
    ex_mem_clear_o = 1'b0;
    mem_wb_clear_o = 1'b0;
    pc_jump_ena_o  = 1'b0;
    pc_jump_addr_o = 32'd0;
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    flush_left_nxt = flush_left;
    timeout_nxt    = 1'b0;
    run_eval       = 1'b0;
    stall_term     = 1'b0;

    case (state)
      RUN: begin
        run_eval   = 1'b1;
        stall_term = mem_stall;
      end
      MEM_WAIT: begin
        if (ram_ack_i) begin
          // The ack cycle is arbitrated like RUN with the memory stall already resolved.
          run_eval = 1'b1;
        end else if (wait_cnt == 16'(MEM_TIMEOUT)) begin
          timeout_nxt  = 1'b1;
          wait_cnt_nxt = 16'd0;
          state_nxt    = RUN;
        end else begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_hold_o   = 1'b1;
          ex_mem_hold_o  = 1'b1;
          mem_wb_clear_o = 1'b1;
          wait_cnt_nxt   = wait_cnt + 16'd1;
        end
      end
      FLUSH: begin
        // Downstream stages already hold bubbles, so new hazards are ignored here.
        if_id_clear_o  = 1'b1;
        flush_left_nxt = flush_left - 3'd1;
        if (flush_left <= 3'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      state_nxt = RUN;
      if (stall_term) begin
        pc_hold_o      = 1'b1;
        if_id_hold_o   = 1'b1;
        id_ex_hold_o   = 1'b1;
        ex_mem_hold_o  = 1'b1;
        mem_wb_clear_o = 1'b1;
        wait_cnt_nxt   = 16'd1;
        state_nxt      = MEM_WAIT;
      end else if (jump_flag_i) begin
        pc_jump_ena_o  = 1'b1;
        pc_jump_addr_o = jump_addr_i;
        if_id_clear_o  = 1'b1;
        id_ex_clear_o  = 1'b1;
        ex_mem_clear_o = 1'b1;
        flush_left_nxt = 3'(FLUSH_CYCLES);
        wait_cnt_nxt   = 16'd0;
        state_nxt      = FLUSH;
      end else begin
        wait_cnt_nxt = 16'd0;
        if (load_use) begin
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_clear_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100M or negedge arst_n) begin
    if (!arst_n) begin
      state      <= RUN;
      wait_cnt   <= 16'd0;
      flush_left <= 3'd0;
      timeout_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      flush_left <= flush_left_nxt;
      timeout_o  <= timeout_nxt;
    end
  end

  assign state_o = state;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk_100M or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (pc_hold_o && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (pc_jump_ena_o && (flush_cnt_o != 32'hFFFF_FFFF)) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected strobe vectors are queued per step and checked mid-cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [3:0]  hold;   // pc, if_id, id_ex, ex_mem
    logic [3:0]  clr;    // if_id, id_ex, ex_mem, mem_wb
    logic        jmp;
    logic [31:0] addr;
    logic [1:0]  st;
    logic        to;
  } obs_t;

  logic        clk_100M = 1'b0;
  logic        arst_n;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ex_ram_r_ena_i;
  logic [4:0]  ex_reg_w_addr_i;
  logic        id_rs1_ena_i, id_rs2_ena_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
  logic        ram_req_i, ram_ack_i;
  logic        pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o;
  logic        if_id_clear_o, id_ex_clear_o, ex_mem_clear_o, mem_wb_clear_o;
  logic        pc_jump_ena_o;
  logic [31:0] pc_jump_addr_o;
  logic [1:0]  state_o;
  logic        timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr_i = 1'b0;
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk_100M = ~clk_100M;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut (
    .clk_100M        (clk_100M),
    .arst_n          (arst_n),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .ex_ram_r_ena_i  (ex_ram_r_ena_i),
    .ex_reg_w_addr_i (ex_reg_w_addr_i),
    .id_rs1_ena_i    (id_rs1_ena_i),
    .id_rs2_ena_i    (id_rs2_ena_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .ram_req_i       (ram_req_i),
    .ram_ack_i       (ram_ack_i),
    .pc_hold_o       (pc_hold_o),
    .if_id_hold_o    (if_id_hold_o),
    .id_ex_hold_o    (id_ex_hold_o),
    .ex_mem_hold_o   (ex_mem_hold_o),
    .if_id_clear_o   (if_id_clear_o),
    .id_ex_clear_o   (id_ex_clear_o),
    .ex_mem_clear_o  (ex_mem_clear_o),
    .mem_wb_clear_o  (mem_wb_clear_o),
    .pc_jump_ena_o   (pc_jump_ena_o),
    .pc_jump_addr_o  (pc_jump_addr_o),
    .state_o         (state_o),
    .timeout_o       (timeout_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_clr_i      (perf_clr_i),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  function automatic obs_t mk(input logic [3:0] hold, input logic [3:0] clr, input logic jmp,
                              input logic [31:0] addr, input logic [1:0] st, input logic to);
    obs_t o;
    o.hold = hold; o.clr = clr; o.jmp = jmp; o.addr = addr; o.st = st; o.to = to;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk({pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o},
              {if_id_clear_o, id_ex_clear_o, ex_mem_clear_o, mem_wb_clear_o},
              pc_jump_ena_o, pc_jump_addr_o, state_o, timeout_o);
  endfunction

  // Queue the expectation for the inputs just driven, compare mid-cycle, then advance to posedge+1.
  task automatic step(input string tag, input obs_t e);
    obs_t  got, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk_100M);
    got  = observe();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, got, want);
    end
    @(posedge clk_100M);
    #1;
  endtask

  task automatic idle_inputs();
    jump_flag_i = 1'b0; jump_addr_i = 32'd0;
    ex_ram_r_ena_i = 1'b0; ex_reg_w_addr_i = 5'd0;
    id_rs1_ena_i = 1'b0; id_rs2_ena_i = 1'b0;
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    ram_req_i = 1'b0; ram_ack_i = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] w, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2);
    ex_ram_r_ena_i = 1'b1; ex_reg_w_addr_i = w;
    id_rs1_ena_i = r1e; id_rs1_addr_i = r1;
    id_rs2_ena_i = r2e; id_rs2_addr_i = r2;
  endtask

  initial begin
    obs_t none0, none2, lu0, lu2, stall0, stall2, flush1;
    none0  = mk(4'b0000, 4'b0000, 1'b0, 32'd0, 2'd0, 1'b0);
    none2  = mk(4'b0000, 4'b0000, 1'b0, 32'd0, 2'd2, 1'b0);
    lu0    = mk(4'b1100, 4'b0100, 1'b0, 32'd0, 2'd0, 1'b0);
    lu2    = mk(4'b1100, 4'b0100, 1'b0, 32'd0, 2'd2, 1'b0);
    stall0 = mk(4'b1111, 4'b0001, 1'b0, 32'd0, 2'd0, 1'b0);
    stall2 = mk(4'b1111, 4'b0001, 1'b0, 32'd0, 2'd2, 1'b0);
    flush1 = mk(4'b0000, 4'b1000, 1'b0, 32'd0, 2'd1, 1'b0);

    arst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_100M);
    #1;
    step("reset", none0);
    arst_n = 1'b1;
    step("idle", none0);

    // Load-use hazards, including the x0 and disabled-read exemptions.
    set_lu(5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
    step("lu_rs2", lu0);
    idle_inputs();
    step("lu_release", none0);
    set_lu(5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    step("lu_rs1", lu0);
    set_lu(5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    step("lu_x0", none0);
    set_lu(5'd5, 1'b0, 5'd5, 1'b0, 5'd5);
    step("lu_no_read", none0);
    set_lu(5'd5, 1'b1, 5'd4, 1'b1, 5'd6);
    step("lu_no_match", none0);
    idle_inputs();

    // Jump, then a FLUSH cycle that must ignore every new hazard.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
    step("jump", mk(4'b0000, 4'b1110, 1'b1, 32'h0000_0100, 2'd0, 1'b0));
    jump_addr_i = 32'h0000_0200; ram_req_i = 1'b1;
    set_lu(5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
    step("flush_ignore", flush1);
    idle_inputs();
    step("flush_done", none0);

    // Memory wait: RUN entry plus three MEM_WAIT holds, release on ack.
    ram_req_i = 1'b1;
    step("mw_entry", stall0);
    for (int i = 0; i < 3; i++) step("mw_hold", stall2);
    ram_ack_i = 1'b1;
    step("mw_ack", none2);
    idle_inputs();
    step("mw_after", none0);

    // Jump behind a memory stall is taken only on the ack cycle.
    ram_req_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0300;
    step("js_entry", stall0);
    step("js_hold", stall2);
    ram_ack_i = 1'b1;
    step("js_ack", mk(4'b0000, 4'b1110, 1'b1, 32'h0000_0300, 2'd2, 1'b0));
    idle_inputs();
    step("js_flush", flush1);
    step("js_run", none0);

    // Load-use arbitrated on the ack cycle.
    ram_req_i = 1'b1;
    step("ml_entry", stall0);
    ram_ack_i = 1'b1;
    set_lu(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
    step("ml_ack_lu", lu2);
    idle_inputs();
    step("ml_run", none0);

    // Timeout after four MEM_WAIT cycles with no ack.
    ram_req_i = 1'b1;
    step("to_entry", stall0);
    for (int i = 0; i < 3; i++) step("to_hold", stall2);
    step("to_exit", none2);
    ram_req_i = 1'b0;
    step("to_pulse", mk(4'b0000, 4'b0000, 1'b0, 32'd0, 2'd0, 1'b1));
    step("to_clear", none0);

    // Asynchronous reset in the middle of FLUSH.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0400;
    step("rf_jump", mk(4'b0000, 4'b1110, 1'b1, 32'h0000_0400, 2'd0, 1'b0));
    idle_inputs();
    arst_n = 1'b0;
    step("rf_reset", none0);
    arst_n = 1'b1;
    step("rf_run", none0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
